// File: rtl/plot_sink.sv
`default_nettype none
// ============================================================================
// Module   : plot_sink
// Purpose  : Accepts one VGA plot strobe per cycle (no backpressure), clips
//            off-screen coordinates, queues in-range pixels in a small FIFO
//            and drains them to a framebuffer port with a valid/ready write
//            handshake (fb_we held until fb_ready).
// Ports    : clk, rst (async, active-high)
//            vga_x/vga_y/vga_colour/vga_plot  - plot input
//            fb_ready                         - framebuffer accepts write
//            clear                            - sync clear of stats
//            fb_addr/fb_wdata/fb_we           - framebuffer write port
//            accepted_count/clipped_count     - saturating statistics
//            overflow                         - sticky drop flag
//            empty                            - nothing queued or in flight
// Revision : 1.0 - initial release
// ============================================================================
module plot_sink #(
   parameter int DEPTH = 8,
   parameter int SCR_W = 160,
   parameter int SCR_H = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  vga_x,
   input  logic [6:0]  vga_y,
   input  logic [2:0]  vga_colour,
   input  logic        vga_plot,
   input  logic        fb_ready,
   input  logic        clear,
   output logic [14:0] fb_addr,
   output logic [2:0]  fb_wdata,
   output logic        fb_we,
   output logic [15:0] accepted_count,
   output logic [15:0] clipped_count,
   output logic        overflow,
   output logic        empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] c_full_lvl = DEPTH[AW:0];

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_WRITE = 1'b1;

   logic [0:0]    r_state;
   logic [17:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [14:0]   r_fb_addr;
   logic [2:0]    r_fb_wdata;
   logic [15:0]   r_acc_cnt;
   logic [15:0]   r_clip_cnt;
   logic          r_overflow;

   logic          w_in_range;
   logic [14:0]   w_addr;
   logic          w_fifo_empty;
   logic          w_fifo_full;
   logic          w_pop;
   logic          w_push_req;
   logic          w_push;
   logic          w_drop;
   logic          w_done;
   logic [17:0]   w_head;

   assign w_in_range   = (int'(vga_x) < SCR_W) && (int'(vga_y) < SCR_H);
   assign w_addr       = 15'(vga_y) * 15'(SCR_W) + 15'(vga_x);
   assign w_fifo_empty = (r_count == '0);
   assign w_fifo_full  = (r_count == c_full_lvl);
   assign w_head       = r_mem[r_rd_ptr];

   // A write completes on any edge where the port is busy and accepted.
   assign w_done       = (r_state == S_WRITE) && fb_ready;
   // The head is consumed when the port is free, or is freeing this edge.
   assign w_pop        = !w_fifo_empty && ((r_state == S_IDLE) || fb_ready);
   assign w_push_req   = vga_plot && w_in_range;
   // A full FIFO still accepts a push if a slot is freed on the same edge.
   assign w_push       = w_push_req && (!w_fifo_full || w_pop);
   assign w_drop       = w_push_req && w_fifo_full && !w_pop;

   // Storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {w_addr, vga_colour};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Drain FSM: the WRITE state is exactly "fb_we asserted".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_fb_addr  <= '0;
         r_fb_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_fb_addr  <= w_head[17:3];
                  r_fb_wdata <= w_head[2:0];
                  r_state    <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (fb_ready) begin
                  if (w_pop) begin
                     r_fb_addr  <= w_head[17:3];
                     r_fb_wdata <= w_head[2:0];
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Statistics: clear takes priority over any same-edge update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_cnt  <= '0;
         r_clip_cnt <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_acc_cnt  <= '0;
         r_clip_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_done && !(&r_acc_cnt)) begin
            r_acc_cnt <= r_acc_cnt + 16'd1;
         end
         if (vga_plot && !w_in_range && !(&r_clip_cnt)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign fb_addr        = r_fb_addr;
   assign fb_wdata       = r_fb_wdata;
   assign fb_we          = (r_state == S_WRITE);
   assign accepted_count = r_acc_cnt;
   assign clipped_count  = r_clip_cnt;
   assign overflow       = r_overflow;
   assign empty          = w_fifo_empty && (r_state == S_IDLE);

endmodule
`default_nettype wire
